// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : ALUCtrl operation encodings and execution-unit FSM state type,
//          shared by alu_exec and every ALU_Ctrl consumer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] c_ALU_AND   = 4'b0000;
    localparam logic [3:0] c_ALU_OR    = 4'b0001;
    localparam logic [3:0] c_ALU_ADD   = 4'b0010;
    localparam logic [3:0] c_ALU_BEQ   = 4'b0011;
    localparam logic [3:0] c_ALU_MUL   = 4'b0100;
    localparam logic [3:0] c_ALU_SLTIU = 4'b0101;
    localparam logic [3:0] c_ALU_SUB   = 4'b0110;
    localparam logic [3:0] c_ALU_SLT   = 4'b0111;
    localparam logic [3:0] c_ALU_ADDI  = 4'b1000;
    localparam logic [3:0] c_ALU_BNE   = 4'b1001;
    localparam logic [3:0] c_ALU_LUI   = 4'b1011;
    localparam logic [3:0] c_ALU_SLL   = 4'b1101;
    localparam logic [3:0] c_ALU_SRA   = 4'b1110;
    localparam logic [3:0] c_ALU_SRAV  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// ============================================================================
// Module : alu_mul_seq
// Brief  : Iterative shift-add multiplier, STEP_BITS multiplier bits per cycle,
//          low 32 bits of the product. Present only with ALU_EXEC_MUL_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef ALU_EXEC_MUL_EN
module alu_mul_seq #(
    parameter int STEP_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [31:0] i_mcand,
    input  logic [31:0] i_mplier,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_product
);

    localparam int c_ITER = 32 / STEP_BITS;

    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;
    logic [5:0]  r_cnt;
    logic [31:0] w_partial;
    logic [31:0] w_acc_next;

    // Low 32 bits of a two's-complement product equal those of the unsigned
    // product, so a plain unsigned shift-add is sufficient.
    always_comb begin
        w_partial = '0;
        for (int j = 0; j < STEP_BITS; j++) begin
            if (r_mplier[j]) begin
                w_partial = w_partial + (r_mcand << j);
            end
        end
    end

    assign w_acc_next = r_acc + w_partial;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
            r_acc    <= '0;
            r_cnt    <= c_ITER[5:0];
        end else if (o_busy) begin
            r_mcand  <= r_mcand << STEP_BITS;
            r_mplier <= r_mplier >> STEP_BITS;
            r_acc    <= w_acc_next;
            r_cnt    <= r_cnt - 6'd1;
        end
    end

    // Done strobes during the final iteration; the product is the accumulator
    // plus that iteration's partial, so the consumer can register it directly.
    assign o_busy    = (r_cnt != 6'd0);
    assign o_done    = (r_cnt == 6'd1);
    assign o_product = w_acc_next;

endmodule
`endif

`default_nettype wire

// File: rtl/alu_exec.sv
// ============================================================================
// Module : alu_exec
// Brief  : Registered ALU execution unit; single-cycle ops plus optional
//          iterative multiply enabled by macro ALU_EXEC_MUL_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_exec
    import alu_pkg::*;
#(
    parameter int MUL_STEP_BITS = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [3:0]  ALUCtrl_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic [4:0]  shamt_i,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic        valid_o
);

    generate
        if (!(MUL_STEP_BITS == 1 || MUL_STEP_BITS == 2 || MUL_STEP_BITS == 4)) begin : g_bad_step
            $error("alu_exec: MUL_STEP_BITS must be 1, 2 or 4");
        end
    endgenerate

    alu_state_t  r_state;
    alu_state_t  w_state_next;
    logic [31:0] r_result;
    logic        r_zero;
    logic        r_valid;

    logic        w_accept;
    logic        w_is_mul;
    logic [31:0] w_alu_result;
    logic        w_alu_zero;
    logic        w_mul_busy;
    logic        w_mul_done;
    logic [31:0] w_mul_product;

    assign ready_o  = (r_state == IDLE);
    assign w_accept = valid_i && ready_o;

`ifdef ALU_EXEC_MUL_EN
    assign w_is_mul = (ALUCtrl_i == c_ALU_MUL);

    alu_mul_seq #(
        .STEP_BITS (MUL_STEP_BITS)
    ) u_mul (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_start   (w_accept && w_is_mul),
        .i_mcand   (src1_i),
        .i_mplier  (src2_i),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );
`else
    assign w_is_mul      = 1'b0;
    assign w_mul_busy    = 1'b0;
    assign w_mul_done    = 1'b0;
    assign w_mul_product = '0;
`endif

    // Single-cycle datapath; mul and unknown codes fall to the zero default.
    always_comb begin
        w_alu_result = '0;
        case (ALUCtrl_i)
            c_ALU_ADD,
            c_ALU_ADDI:  w_alu_result = src1_i + src2_i;
            c_ALU_SUB,
            c_ALU_BEQ,
            c_ALU_BNE:   w_alu_result = src1_i - src2_i;
            c_ALU_AND:   w_alu_result = src1_i & src2_i;
            c_ALU_OR:    w_alu_result = src1_i | src2_i;
            c_ALU_SLT:   w_alu_result = {31'b0, $signed(src1_i) < $signed(src2_i)};
            c_ALU_SLTIU: w_alu_result = {31'b0, src1_i < src2_i};
            c_ALU_SLL:   w_alu_result = src2_i << shamt_i;
            c_ALU_SRA:   w_alu_result = $signed(src2_i) >>> shamt_i;
            c_ALU_SRAV:  w_alu_result = $signed(src2_i) >>> src1_i[4:0];
            c_ALU_LUI:   w_alu_result = src2_i << 16;
            default:     w_alu_result = '0;
        endcase

        w_alu_zero = (w_alu_result == 32'd0);
        if (ALUCtrl_i == c_ALU_BEQ) begin
            w_alu_zero = (src1_i == src2_i);
        end else if (ALUCtrl_i == c_ALU_BNE) begin
            w_alu_zero = (src1_i != src2_i);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_state_next = MUL;
                end
            end
            MUL: begin
                if (w_mul_done) begin
                    w_state_next = DONE;
                end else if (!w_mul_busy) begin
                    w_state_next = IDLE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept && !w_is_mul) begin
                r_result <= w_alu_result;
                r_zero   <= w_alu_zero;
                r_valid  <= 1'b1;
            end else if (r_state == MUL && w_mul_done) begin
                r_result <= w_mul_product;
                r_zero   <= (w_mul_product == 32'd0);
                r_valid  <= 1'b1;
            end
        end
    end

    assign result_o = r_result;
    assign zero_o   = r_zero;
    assign valid_o  = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
// Module : tb_alu_exec
// Brief  : Directed vector table plus multi-cycle sequences for alu_exec;
//          multiply sequences are selected by ALU_EXEC_MUL_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_exec;

    localparam int c_STEP = 1;
    localparam int c_LAT  = 1 + 32 / c_STEP;

    localparam logic [3:0] c_AND   = 4'b0000;
    localparam logic [3:0] c_OR    = 4'b0001;
    localparam logic [3:0] c_ADD   = 4'b0010;
    localparam logic [3:0] c_BEQ   = 4'b0011;
    localparam logic [3:0] c_MUL   = 4'b0100;
    localparam logic [3:0] c_SLTIU = 4'b0101;
    localparam logic [3:0] c_SUB   = 4'b0110;
    localparam logic [3:0] c_SLT   = 4'b0111;
    localparam logic [3:0] c_ADDI  = 4'b1000;
    localparam logic [3:0] c_BNE   = 4'b1001;
    localparam logic [3:0] c_UNDEF = 4'b1010;
    localparam logic [3:0] c_LUI   = 4'b1011;
    localparam logic [3:0] c_SLL   = 4'b1101;
    localparam logic [3:0] c_SRA   = 4'b1110;
    localparam logic [3:0] c_SRAV  = 4'b1111;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  alu_ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  shamt;
    logic [31:0] result_o;
    logic        zero_o;
    logic        valid_o;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        zero;
        bit          chk_res;
    } vec_t;

    vec_t vecs[$];

    alu_exec #(
        .MUL_STEP_BITS (c_STEP)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .ALUCtrl_i (alu_ctrl),
        .src1_i    (src1),
        .src2_i    (src2),
        .shamt_i   (shamt),
        .result_o  (result_o),
        .zero_o    (zero_o),
        .valid_o   (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] sh, input logic [31:0] res, input logic zero,
                                    input bit chk_res);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.sh = sh;
        v.res = res; v.zero = zero; v.chk_res = chk_res;
        vecs.push_back(v);
    endfunction

    // Issue one mul and watch the outputs cycle by cycle; optionally scramble
    // the operand inputs and pulse an add while the unit is busy.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input bit disturb);
        int          seen;
        int          extra;
        int          ready_bad;
        logic [31:0] got_res;
        logic        got_zero;
        seen = -1; extra = 0; ready_bad = 0; got_res = '0; got_zero = 1'b0;
        valid_i = 1'b1; alu_ctrl = c_MUL; src1 = a; src2 = b; shamt = 5'd0;
        for (int k = 1; k <= c_LAT + 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                valid_i = 1'b0;
                if (disturb) begin
                    alu_ctrl = c_ADD; src1 = 32'hDEAD_BEEF; src2 = 32'h0000_0001;
                end
            end
            if (disturb && k == 5) valid_i = 1'b1;
            if (k == 6) valid_i = 1'b0;
            if (valid_o) begin
                if (seen < 0) begin
                    seen = k; got_res = result_o; got_zero = zero_o;
                end else begin
                    extra++;
                end
            end
            if (k <= c_LAT && ready_o !== 1'b0) ready_bad++;
        end
        check({tag, " latency"}, 32'(seen), 32'(c_LAT));
        check({tag, " result"}, got_res, exp);
        check({tag, " zero"}, {31'b0, got_zero}, {31'b0, exp == 32'd0});
        check({tag, " ready low while busy"}, 32'(ready_bad), 32'd0);
        check({tag, " single valid pulse"}, 32'(extra), 32'd0);
        check({tag, " ready after"}, {31'b0, ready_o}, 32'd1);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; valid_i = 1'b0; alu_ctrl = c_ADD;
        src1 = '0; src2 = '0; shamt = '0;

        add_vec(c_ADD,   32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0, 1'b1);
        add_vec(c_SUB,   32'd5,         32'd5,         5'd0,  32'h0000_0000, 1'b1, 1'b1);
        add_vec(c_ADDI,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b1);
        add_vec(c_AND,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'h00F0_00F0, 1'b0, 1'b1);
        add_vec(c_OR,    32'hF000_0000, 32'h0000_000F, 5'd0,  32'hF000_000F, 1'b0, 1'b1);
        add_vec(c_SLT,   32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1'b1);
        add_vec(c_SLT,   32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b1, 1'b1);
        add_vec(c_SLTIU, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0001, 1'b0, 1'b1);
        add_vec(c_SLTIU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b1);
        add_vec(c_SLL,   32'h0,         32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b1);
        add_vec(c_SLL,   32'h0,         32'h0000_1234, 5'd0,  32'h0000_1234, 1'b0, 1'b1);
        add_vec(c_SRA,   32'h0,         32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b1);
        add_vec(c_SRA,   32'h0,         32'h4000_0000, 5'd0,  32'h4000_0000, 1'b0, 1'b1);
        add_vec(c_SRAV,  32'hFFFF_FFE4, 32'h8000_0000, 5'd0,  32'hF800_0000, 1'b0, 1'b1);
        add_vec(c_SRAV,  32'h0,         32'h8000_0000, 5'd5,  32'h8000_0000, 1'b0, 1'b1);
        add_vec(c_LUI,   32'h0,         32'h0000_1234, 5'd0,  32'h1234_0000, 1'b0, 1'b1);
        add_vec(c_BEQ,   32'd7,         32'd7,         5'd0,  32'h0,         1'b1, 1'b0);
        add_vec(c_BEQ,   32'd7,         32'd8,         5'd0,  32'h0,         1'b0, 1'b0);
        add_vec(c_BNE,   32'd3,         32'd3,         5'd0,  32'h0,         1'b0, 1'b0);
        add_vec(c_BNE,   32'd3,         32'd4,         5'd0,  32'h0,         1'b1, 1'b0);
        add_vec(c_UNDEF, 32'h1234_5678, 32'h1111_1111, 5'd3,  32'h0000_0000, 1'b1, 1'b1);
        add_vec(c_SUB,   32'd3,         32'd5,         5'd0,  32'hFFFF_FFFE, 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        check("reset result", result_o, 32'h0);
        check("reset zero", {31'b0, zero_o}, 32'd0);
        check("reset valid", {31'b0, valid_o}, 32'd0);
        check("reset ready", {31'b0, ready_o}, 32'd1);
        rst = 1'b0;

        // Back-to-back issue: every vector is driven on the cycle after the last.
        for (int i = 0; i < vecs.size(); i++) begin
            valid_i = 1'b1; alu_ctrl = vecs[i].op;
            src1 = vecs[i].a; src2 = vecs[i].b; shamt = vecs[i].sh;
            @(negedge clk);
            check($sformatf("vec%0d valid", i), {31'b0, valid_o}, 32'd1);
            check($sformatf("vec%0d ready", i), {31'b0, ready_o}, 32'd1);
            if (vecs[i].chk_res) check($sformatf("vec%0d result", i), result_o, vecs[i].res);
            check($sformatf("vec%0d zero", i), {31'b0, zero_o}, {31'b0, vecs[i].zero});
        end
        valid_i = 1'b0;
        @(negedge clk);
        check("idle no valid", {31'b0, valid_o}, 32'd0);
        check("idle result held", result_o, 32'hFFFF_FFFE);

        // Reset wins over a simultaneous request.
        valid_i = 1'b1; alu_ctrl = c_ADD; src1 = 32'd1; src2 = 32'd1; rst = 1'b1;
        @(negedge clk);
        check("rst+valid valid", {31'b0, valid_o}, 32'd0);
        check("rst+valid result", result_o, 32'h0);
        rst = 1'b0; valid_i = 1'b0;
        @(negedge clk);

`ifdef ALU_EXEC_MUL_EN
        run_mul("mul -3*7", 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 1'b1);
        run_mul("mul x*0", 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0);
        run_mul("mul min*-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);

        begin
            int late_valid;
            late_valid = 0;
            valid_i = 1'b1; alu_ctrl = c_MUL; src1 = 32'h1234_5678; src2 = 32'd3;
            @(negedge clk);
            valid_i = 1'b0;
            for (int k = 2; k <= 10; k++) begin
                @(negedge clk);
                if (valid_o) late_valid++;
            end
            rst = 1'b1;
            @(negedge clk);
            check("mul abort valid", {31'b0, valid_o}, 32'd0);
            check("mul abort ready", {31'b0, ready_o}, 32'd1);
            check("mul abort result", result_o, 32'h0);
            rst = 1'b0;
            for (int k = 0; k < c_LAT + 8; k++) begin
                @(negedge clk);
                if (valid_o) late_valid++;
            end
            check("mul abort no pulse", 32'(late_valid), 32'd0);
        end
`else
        valid_i = 1'b1; alu_ctrl = c_ADD; src1 = 32'd2; src2 = 32'd3;
        @(negedge clk);
        check("pre-mul add", result_o, 32'd5);
        alu_ctrl = c_MUL; src1 = 32'd5; src2 = 32'd6;
        @(negedge clk);
        check("nomul valid", {31'b0, valid_o}, 32'd1);
        check("nomul result", result_o, 32'h0);
        check("nomul zero", {31'b0, zero_o}, 32'd1);
        check("nomul ready", {31'b0, ready_o}, 32'd1);
        valid_i = 1'b0;
        @(negedge clk);
        check("nomul single pulse", {31'b0, valid_o}, 32'd0);
        check("nomul ready after", {31'b0, ready_o}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter MUL_STEP_BITS, default 1, multiplier bits retired per cycle; legal values 1, 2, 4.
REQ-002 SHALL have port clk_i  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port valid_i  input  1  operation request, sampled only when ready_o=1.
REQ-005 SHALL have port ready_o  output  1  unit idle and able to accept an operation.
REQ-006 SHALL have port ALUCtrl_i  input  4  operation code from ALU_Ctrl.
REQ-007 SHALL have port src1_i  input  32  operand 1 (rs).
REQ-008 SHALL have port src2_i  input  32  operand 2 (rt or immediate).
REQ-009 SHALL have port shamt_i  input  5  shift amount for sll/sra.
REQ-010 SHALL have port result_o  output  32  registered result, held until next valid_o.
REQ-011 SHALL have port zero_o  output  1  registered branch-taken flag.
REQ-012 SHALL have port valid_o  output  1  one-cycle pulse marking new result_o/zero_o.

Function
REQ-013 SHALL decode: 0010/1000 add, 0110 sub, 0000 and, 0001 or, 0111 slt (signed), 0101 sltiu (unsigned), 1101 sll src2<<shamt_i, 1110 sra src2>>>shamt_i, 1111 srav src2>>>src1[4:0], 1011 lui src2<<16, 0011 beq, 1001 bne, 0100 mul.
REQ-014 SHALL use 32-bit wrap-around for add/sub/mul (low 32 bits of product, signed operands); no overflow trap.
REQ-015 SHALL set zero_o=(src1==src2) for beq, zero_o=(src1!=src2) for bne, zero_o=(result==0) for all other ops.
REQ-016 SHALL return result_o=0, zero_o=1 with normal single-op latency for undefined codes.
REQ-017 SHALL implement FSM states IDLE, MUL, DONE; ready_o=1 only in IDLE.
REQ-018 SHALL, for non-mul op accepted in cycle N, pulse valid_o in cycle N+1 and remain in IDLE (back-to-back issue each cycle).
REQ-019 SHALL, for mul accepted in cycle N, go IDLE->MUL, iterate 32/MUL_STEP_BITS cycles, go MUL->DONE, pulse valid_o in DONE, return to IDLE; valid_o at N+1+32/MUL_STEP_BITS.
REQ-020 SHALL latch operands at acceptance; changes on src*_i/ALUCtrl_i during MUL SHALL not affect the result.
REQ-021 SHALL ignore valid_i while ready_o=0 (no queuing, no error).
REQ-022 SHALL handle shift amounts 0 (passthrough) and 31 correctly; srav uses only src1[4:0].
REQ-023 SHALL produce mul results for 0x80000000 * 0xFFFFFFFF = 0x80000000 and x*0 = 0 without early termination changing latency.

Reset
REQ-024 SHALL, with rst_i=1 at a clock edge, force state IDLE, result_o=0, zero_o=0, valid_o=0, ready_o=1 after that edge.
REQ-025 SHALL abort an in-flight mul on reset with no valid_o pulse; reset dominates valid_i in the same cycle.

Configuration
REQ-026 SHALL, with ALU_EXEC_MUL_EN defined, implement the iterative multiplier and MUL/DONE states per REQ-019.
REQ-027 SHALL, without ALU_EXEC_MUL_EN, omit multiplier logic; code 0100 then behaves as undefined per REQ-016, ready_o constant 1 outside reset.

Structure
REQ-028 SHALL place ALUCtrl encodings as localparams and the FSM state typedef in shared package alu_pkg, also used by ALU_Ctrl consumers.
REQ-029 SHALL implement the shift-add multiplier as sub-module alu_mul_seq (start/busy/done, 32-bit signed low product).
REQ-030 SHALL keep single-cycle ops as combinational logic feeding the output register inside alu_exec.

Verification
REQ-031 SHALL test add 0x7FFFFFFF+1 -> result_o=0x80000000, zero_o=0, valid_o one cycle later; then sub 5-5 next cycle -> result 0, zero_o=1.
REQ-032 SHALL test mul 0xFFFFFFFD*7 (STEP=1) -> result_o=0xFFFFFFEB, valid_o exactly 33 cycles after acceptance, ready_o=0 throughout.
REQ-033 SHALL test valid_i pulsed with add during mul -> ignored; only the mul result emitted.
REQ-034 SHALL test rst_i asserted 10 cycles into mul -> no valid_o, ready_o=1, result_o=0 next cycle.
REQ-035 SHALL test sra 0x80000000 shamt 31 -> 0xFFFFFFFF; sltiu 1 vs 0xFFFFFFFF -> 1; bne 3,3 -> zero_o=0; lui 0x1234 -> 0x12340000.
REQ-036 SHALL test build without ALU_EXEC_MUL_EN: code 0100 -> result 0, zero_o=1, valid_o after 1 cycle.
